branch_predict_unit: RTL and testbench

Parametrised successor to the decode-stage branch decision logic. Adds a direct-mapped branch history table (BHT) of 2-bit saturating counters that predicts branches in fetch. It resolves the actual branch condition in decode and flags mispredictions for front-end redirect/flush. It also keeps saturating branch and mispredict statistics counters. Sits between the fetch PC mux and the decode-stage comparator and hazard unit.

---
 rtl/branch_predict_unit.sv | 122 ++++++++++++
 tb/tb_branch_predict_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BHT of 2-bit counters predicts in fetch,
// resolves in decode, flags mispredictions and keeps saturating statistics.
module branch_predict_unit #(
    parameter int unsigned IDX_BITS   = 6,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned CNT_W      = 16,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_d,
    input  logic [PC_W-1:0]  pc_f,
    input  logic [PC_W-1:0]  pc_d,
    input  logic [2:0]       branch_d,
    input  logic             equal_d,
    input  logic             nequal_d,
    input  logic             zero_d,
    input  logic             gtz_d,
    input  logic             ltz_d,
    input  logic             clr_stats,
    output logic             pred_taken_f,
    output logic             pcsrc_d,
    output logic             mispredict_d,
    output logic             pred_taken_d,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [1:0]          bht_q [ENTRIES];
    logic [1:0]          bht_cur;
    logic [1:0]          bht_nxt;
    logic [IDX_BITS-1:0] idx_f;
    logic [IDX_BITS-1:0] idx_d;
    logic                cond;
    logic                is_br;
    logic                valid_br;
    logic                pred_q, pred_d;
    logic [CNT_W-1:0]    br_q, br_d;
    logic [CNT_W-1:0]    mis_q, mis_d;
    logic                unused_pc_bits;

    assign idx_f = pc_f[IDX_BITS+1:2];
    assign idx_d = pc_d[IDX_BITS+1:2];
    assign unused_pc_bits = ^{pc_f[PC_W-1:IDX_BITS+2], pc_f[1:0],
                              pc_d[PC_W-1:IDX_BITS+2], pc_d[1:0]};

    // Branch condition decode; 000 and 111 are not branches
    always_comb begin
        cond  = 1'b0;
        is_br = 1'b1;
        case (branch_d)
            3'b001:  cond = zero_d | gtz_d;
            3'b010:  cond = ltz_d;
            3'b011:  cond = equal_d;
            3'b100:  cond = nequal_d;
            3'b101:  cond = ltz_d | zero_d;
            3'b110:  cond = gtz_d;
            default: is_br = 1'b0;
        endcase
    end

    assign valid_br     = is_br & ~stall_d;
    assign pcsrc_d      = valid_br & cond;
    assign mispredict_d = valid_br & (cond != pred_q);
    assign pred_taken_d = pred_q;
    assign pred_taken_f = bht_q[idx_f][1];
    assign br_count     = br_q;
    assign mis_count    = mis_q;

    // Saturating 2-bit counter step for the resolving entry
    always_comb begin
        bht_cur = bht_q[idx_d];
        bht_nxt = bht_cur;
        if (cond) begin
            if (bht_cur != 2'b11) bht_nxt = 2'(bht_cur + 2'd1);
        end else begin
            if (bht_cur != 2'b00) bht_nxt = 2'(bht_cur - 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) bht_q[i] <= INIT_STATE;
        end else if (valid_br) begin
            bht_q[idx_d] <= bht_nxt;
        end
    end

    // Carried prediction: squashed to 0 on a mispredict, held on stall
    always_comb begin
        pred_d = pred_q;
        if (!stall_d) pred_d = mispredict_d ? 1'b0 : pred_taken_f;
    end

    // Statistics counters: clear wins, otherwise saturate at all-ones
    always_comb begin
        br_d  = br_q;
        mis_d = mis_q;
        if (clr_stats) begin
            br_d  = '0;
            mis_d = '0;
        end else if (valid_br) begin
            if (br_q != '1) br_d = CNT_W'(br_q + CNT_W'(1));
            if (mispredict_d && (mis_q != '1)) mis_d = CNT_W'(mis_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q <= 1'b0;
            br_q   <= '0;
            mis_q  <= '0;
        end else begin
            pred_q <= pred_d;
            br_q   <= br_d;
            mis_q  <= mis_d;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (CNT_W=4 instance).
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_d;
    logic [31:0] pc_f, pc_d;
    logic [2:0]  branch_d;
    logic        equal_d, nequal_d, zero_d, gtz_d, ltz_d;
    logic        clr_stats;
    logic        pred_taken_f, pcsrc_d, mispredict_d, pred_taken_d;
    logic [3:0]  br_count, mis_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .IDX_BITS(6), .PC_W(32), .CNT_W(4), .INIT_STATE(2'b01)
    ) dut (
        .clk(clk), .rst(rst), .stall_d(stall_d), .pc_f(pc_f), .pc_d(pc_d),
        .branch_d(branch_d), .equal_d(equal_d), .nequal_d(nequal_d),
        .zero_d(zero_d), .gtz_d(gtz_d), .ltz_d(ltz_d), .clr_stats(clr_stats),
        .pred_taken_f(pred_taken_f), .pcsrc_d(pcsrc_d),
        .mispredict_d(mispredict_d), .pred_taken_d(pred_taken_d),
        .br_count(br_count), .mis_count(mis_count)
    );

    function automatic logic [31:0] addr(input int idx);
        return 32'h0040_0000 | (32'(idx) << 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        equal_d = 0; nequal_d = 0; zero_d = 0; gtz_d = 0; ltz_d = 0;
    endtask

    task automatic test_reset();
        rst = 1; stall_d = 0; branch_d = 3'b000; clr_stats = 0;
        pc_f = 32'h0040_0010; pc_d = 32'h0040_0010;
        clear_flags();
        tick(); tick();
        rst = 0;
        #1;
        checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL reset_pred_f got %0b want 0", pred_taken_f); end
        checks++; if (br_count !== 4'd0) begin errors++; $display("FAIL reset_br got %0d want 0", br_count); end
        checks++; if (mis_count !== 4'd0) begin errors++; $display("FAIL reset_mis got %0d want 0", mis_count); end
        checks++; if (pred_taken_d !== 1'b0) begin errors++; $display("FAIL reset_pred_d got %0b want 0", pred_taken_d); end
    endtask

    // Fetch cycle then resolve cycle, four times; entry 4 walks 01->10->11->11
    task automatic test_beq_training();
        logic exp_pf [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic exp_mp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        pc_f = addr(4); pc_d = addr(4);
        for (int r = 0; r < 4; r++) begin
            branch_d = 3'b000; clear_flags();
            #1;
            checks++; if (pred_taken_f !== exp_pf[r]) begin errors++; $display("FAIL beq_lookup%0d got %0b want %0b", r, pred_taken_f, exp_pf[r]); end
            tick();
            branch_d = 3'b011; equal_d = 1;
            #1;
            checks++; if (mispredict_d !== exp_mp[r]) begin errors++; $display("FAIL beq_mispredict%0d got %0b want %0b", r, mispredict_d, exp_mp[r]); end
            checks++; if (pcsrc_d !== 1'b1) begin errors++; $display("FAIL beq_pcsrc%0d got %0b want 1", r, pcsrc_d); end
            tick();
        end
        branch_d = 3'b000; clear_flags();
        #1;
        checks++; if (br_count !== 4'd4) begin errors++; $display("FAIL beq_br got %0d want 4", br_count); end
        checks++; if (mis_count !== 4'd1) begin errors++; $display("FAIL beq_mis got %0d want 1", mis_count); end
        checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL beq_final_pred got %0b want 1", pred_taken_f); end
    endtask

    // Resolve and fetch the same index in one cycle: old value, then new
    task automatic test_same_cycle_bne();
        pc_f = addr(8); pc_d = addr(8);
        branch_d = 3'b000; clear_flags();
        tick();
        branch_d = 3'b100; nequal_d = 1;
        #1;
        checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL bne_old_value got %0b want 0", pred_taken_f); end
        checks++; if (mispredict_d !== 1'b1) begin errors++; $display("FAIL bne_mispredict got %0b want 1", mispredict_d); end
        tick();
        branch_d = 3'b000; clear_flags();
        #1;
        checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL bne_new_value got %0b want 1", pred_taken_f); end
        checks++; if (pred_taken_d !== 1'b0) begin errors++; $display("FAIL bne_squash got %0b want 0", pred_taken_d); end
        checks++; if (br_count !== 4'd5 || mis_count !== 4'd2) begin errors++; $display("FAIL bne_counts got %0d/%0d want 5/2", br_count, mis_count); end
    endtask

    task automatic test_stall();
        pc_f = addr(4); pc_d = addr(12);
        branch_d = 3'b000; clear_flags();
        tick();
        stall_d = 1; branch_d = 3'b010; ltz_d = 1; pc_f = addr(12);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (pcsrc_d !== 1'b0 || mispredict_d !== 1'b0) begin errors++; $display("FAIL stall_out%0d got %0b/%0b want 0/0", c, pcsrc_d, mispredict_d); end
            checks++; if (pred_taken_d !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got %0b want 1", c, pred_taken_d); end
            tick();
        end
        checks++; if (br_count !== 4'd5 || mis_count !== 4'd2) begin errors++; $display("FAIL stall_counts got %0d/%0d want 5/2", br_count, mis_count); end
        checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL stall_bht got %0b want 0", pred_taken_f); end
        stall_d = 0;
        #1;
        checks++; if (pcsrc_d !== 1'b1 || mispredict_d !== 1'b0) begin errors++; $display("FAIL release_out got %0b/%0b want 1/0", pcsrc_d, mispredict_d); end
        tick();
        checks++; if (br_count !== 4'd6) begin errors++; $display("FAIL release_br got %0d want 6", br_count); end
        checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL release_bht got %0b want 1", pred_taken_f); end
        ltz_d = 0;
        #1;
        checks++; if (pcsrc_d !== 1'b0 || mispredict_d !== 1'b0) begin errors++; $display("FAIL bltz_nt_out got %0b/%0b want 0/0", pcsrc_d, mispredict_d); end
        tick();
        checks++; if (br_count !== 4'd7 || pred_taken_f !== 1'b0) begin errors++; $display("FAIL single_update got br=%0d pred=%0b want 7/0", br_count, pred_taken_f); end
    endtask

    task automatic test_nonbranch();
        logic [2:0] nb [2] = '{3'b111, 3'b000};
        pc_f = addr(12); pc_d = addr(20);
        for (int k = 0; k < 2; k++) begin
            branch_d = nb[k];
            equal_d = 1; nequal_d = 1; zero_d = 1; gtz_d = 1; ltz_d = 1;
            #1;
            checks++; if (pcsrc_d !== 1'b0 || mispredict_d !== 1'b0) begin errors++; $display("FAIL nonbranch%0d got %0b/%0b want 0/0", k, pcsrc_d, mispredict_d); end
            tick();
            checks++; if (br_count !== 4'd7) begin errors++; $display("FAIL nonbranch_cnt%0d got %0d want 7", k, br_count); end
        end
        clear_flags(); zero_d = 1; branch_d = 3'b101;
        #1;
        checks++; if (pcsrc_d !== 1'b1 || mispredict_d !== 1'b1) begin errors++; $display("FAIL blez_zero got %0b/%0b want 1/1", pcsrc_d, mispredict_d); end
        tick();
        branch_d = 3'b110;
        #1;
        checks++; if (pcsrc_d !== 1'b0 || mispredict_d !== 1'b0) begin errors++; $display("FAIL bgtz_zero got %0b/%0b want 0/0", pcsrc_d, mispredict_d); end
        tick();
        checks++; if (br_count !== 4'd9 || mis_count !== 4'd3) begin errors++; $display("FAIL cond_counts got %0d/%0d want 9/3", br_count, mis_count); end
    endtask

    task automatic test_saturation_clear_reset();
        pc_f = addr(31); pc_d = addr(30);
        clear_flags(); branch_d = 3'b011; equal_d = 1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 6) begin
                checks++; if (br_count !== 4'd15 || mis_count !== 4'd9) begin errors++; $display("FAIL sat_mid got %0d/%0d want 15/9", br_count, mis_count); end
            end
        end
        checks++; if (br_count !== 4'd15 || mis_count !== 4'd15) begin errors++; $display("FAIL sat_end got %0d/%0d want 15/15", br_count, mis_count); end
        clr_stats = 1;
        tick();
        clr_stats = 0;
        branch_d = 3'b000; clear_flags();
        #1;
        checks++; if (br_count !== 4'd0 || mis_count !== 4'd0) begin errors++; $display("FAIL clr_priority got %0d/%0d want 0/0", br_count, mis_count); end
        tick();
        pc_f = addr(4);
        #1;
        checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL pre_reset_bht got %0b want 1", pred_taken_f); end
        rst = 1; stall_d = 1; branch_d = 3'b011; equal_d = 1; clr_stats = 0; pc_d = addr(4);
        tick();
        rst = 0; stall_d = 0; branch_d = 3'b000; clear_flags();
        #1;
        checks++; if (br_count !== 4'd0 || mis_count !== 4'd0 || pred_taken_d !== 1'b0) begin errors++; $display("FAIL midreset_regs got %0d/%0d/%0b want 0/0/0", br_count, mis_count, pred_taken_d); end
        for (int i = 0; i < 64; i++) begin
            pc_f = addr(i);
            #1;
            checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL midreset_entry%0d got %0b want 0", i, pred_taken_f); end
        end
        // One taken step from 01 must reach 10; from 00 it would not
        pc_f = addr(30); pc_d = addr(30); branch_d = 3'b011; equal_d = 1;
        tick();
        branch_d = 3'b000; clear_flags();
        #1;
        checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL midreset_init01 got %0b want 1", pred_taken_f); end
    endtask

    initial begin
        test_reset();
        test_beq_training();
        test_same_cycle_bne();
        test_stall();
        test_nonbranch();
        test_saturation_clear_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
